// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared types and frame/button constants for the pad poller
package pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_DONE
  } pad_state_t;

  localparam int         FRAME_BITS = 16;
  localparam logic [3:0] LAST_BIT   = 4'd15;
  localparam logic [3:0] SNES_ID    = 4'b1111;

  // Bit positions shared by both pad types
  localparam int BIT_SELECT = 2;
  localparam int BIT_START  = 3;
  localparam int BIT_UP     = 4;
  localparam int BIT_DOWN   = 5;
  localparam int BIT_LEFT   = 6;
  localparam int BIT_RIGHT  = 7;

  // NES serial order
  localparam int NES_A = 0;
  localparam int NES_B = 1;

  // SNES serial order
  localparam int SNES_B = 0;
  localparam int SNES_Y = 1;
  localparam int SNES_A = 8;
  localparam int SNES_X = 9;
  localparam int SNES_L = 10;
  localparam int SNES_R = 11;

  typedef struct packed {
    logic is_snes;
    logic a;
    logic b;
    logic sel;
    logic start;
    logic up;
    logic down;
    logic left;
    logic right;
    logic x;
    logic y;
    logic l;
    logic r;
  } pad_buttons_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchroniser
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input; resets to the line's idle level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pad_serial_reader.sv
// rtl/pad_serial_reader.sv - NES/SNES pad poller with type auto-detect and decode
module pad_serial_reader
  import pad_pkg::*;
#(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int POLL_CYCLES  = 416667
) (
  input  logic system_clk_25MHz,
  input  logic rst_n,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A_out,
  output logic B_out,
  output logic select_out,
  output logic start_out,
  output logic up_out,
  output logic down_out,
  output logic left_out,
  output logic right_out,
  output logic X_out,
  output logic Y_out,
  output logic L_out,
  output logic R_out,
  output logic is_snes,
  output logic buttons_valid
);

  localparam int POLL_W    = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES);
  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PHASE_W   = (PHASE_MAX < 2) ? 1 : $clog2(PHASE_MAX);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);

  pad_state_t              r_state;
  logic [POLL_W-1:0]       r_poll_cnt;
  logic [PHASE_W-1:0]      r_phase;
  logic [3:0]              r_bit;
  logic [FRAME_BITS-1:0]   r_raw;
  logic                    r_latch;
  logic                    r_clk;
  logic                    r_valid;
  pad_buttons_t            r_btn;

  logic                    w_ds;
  logic                    w_tick;
  logic [11:0]             w_pressed;
  pad_buttons_t            w_dec;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_data (
    .i_clk   (system_clk_25MHz),
    .i_rst_n (rst_n),
    .i_d     (pad_data),
    .o_q     (w_ds)
  );

  // Free-running poll timer; a frame starts whenever it reads zero while idle
  always_ff @(posedge system_clk_25MHz) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (r_poll_cnt == POLL_LAST) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + POLL_W'(1);
    end
  end

  assign w_tick = (r_poll_cnt == '0);

  // Decode the captured frame; pad type comes from the top nibble
  always_comb begin
    w_pressed     = ~r_raw[11:0];
    w_dec         = '0;
    w_dec.is_snes = (r_raw[15:12] == SNES_ID);
    w_dec.sel     = w_pressed[BIT_SELECT];
    w_dec.start   = w_pressed[BIT_START];
    w_dec.up      = w_pressed[BIT_UP];
    w_dec.down    = w_pressed[BIT_DOWN];
    w_dec.left    = w_pressed[BIT_LEFT];
    w_dec.right   = w_pressed[BIT_RIGHT];
    if (w_dec.is_snes) begin
      w_dec.a = w_pressed[SNES_A];
      w_dec.b = w_pressed[SNES_B];
      w_dec.x = w_pressed[SNES_X];
      w_dec.y = w_pressed[SNES_Y];
      w_dec.l = w_pressed[SNES_L];
      w_dec.r = w_pressed[SNES_R];
    end else begin
      w_dec.a = w_pressed[NES_A];
      w_dec.b = w_pressed[NES_B];
    end
  end

  // Frame sequencer: latch, 15 clock pulses sampling one bit each, then publish
  always_ff @(posedge system_clk_25MHz) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_raw   <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b0;
      r_valid <= 1'b0;
      r_btn   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_latch <= 1'b1;
            r_phase <= '0;
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (r_phase == LATCH_LAST) begin
            r_raw[0] <= w_ds;
            r_latch  <= 1'b0;
            r_clk    <= 1'b1;
            r_bit    <= 4'd1;
            r_phase  <= '0;
            r_state  <= ST_PULSE_HI;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_PULSE_HI: begin
          if (r_phase == HALF_LAST) begin
            r_raw[r_bit] <= w_ds;
            r_clk        <= 1'b0;
            r_phase      <= '0;
            r_state      <= ST_PULSE_LO;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_PULSE_LO: begin
          if (r_phase == HALF_LAST) begin
            r_phase <= '0;
            if (r_bit == LAST_BIT) begin
              r_state <= ST_DONE;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_clk   <= 1'b1;
              r_state <= ST_PULSE_HI;
            end
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
        end
        ST_DONE: begin
          r_btn   <= w_dec;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pad_latch     = r_latch;
  assign pad_clk       = r_clk;
  assign buttons_valid = r_valid;
  assign is_snes       = r_btn.is_snes;
  assign A_out         = r_btn.a;
  assign B_out         = r_btn.b;
  assign select_out    = r_btn.sel;
  assign start_out     = r_btn.start;
  assign up_out        = r_btn.up;
  assign down_out      = r_btn.down;
  assign left_out      = r_btn.left;
  assign right_out     = r_btn.right;
  assign X_out         = r_btn.x;
  assign Y_out         = r_btn.y;
  assign L_out         = r_btn.l;
  assign R_out         = r_btn.r;

endmodule

// File: tb/tb_pad_serial_reader.sv
// tb/tb_pad_serial_reader.sv - randomized self-checking bench for pad_serial_reader
module tb_pad_serial_reader;

  localparam int L = 12;
  localparam int H = 6;
  localparam int P = 400;
  localparam int VALID_PH = L + 30 * H + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pad_data;
  logic pad_latch, pad_clk, buttons_valid, is_snes;
  logic A_out, B_out, select_out, start_out, up_out, down_out, left_out, right_out;
  logic X_out, Y_out, L_out, R_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] next_pat  = 16'hFFFF;
  logic [15:0] pad_shift = 16'hFFFF;
  logic        tie       = 1'b0;
  logic        chk_en    = 1'b0;

  // order of button columns: A,B,sel,start,up,down,left,right,X,Y,L,R
  int nes_map  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, -1, -1, -1, -1};
  int snes_map [12] = '{8, 0, 2, 3, 4, 5, 6, 7, 9, 1, 10, 11};

  pad_serial_reader #(
    .LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_CYCLES(P)
  ) dut (
    .system_clk_25MHz(clk), .rst_n(rst_n), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .A_out(A_out), .B_out(B_out), .select_out(select_out), .start_out(start_out),
    .up_out(up_out), .down_out(down_out), .left_out(left_out), .right_out(right_out),
    .X_out(X_out), .Y_out(Y_out), .L_out(L_out), .R_out(R_out),
    .is_snes(is_snes), .buttons_valid(buttons_valid)
  );

  always #5 clk = ~clk;

  // pad behaviour: parallel load on latch, shift on each pad clock rise
  always @(posedge pad_latch) pad_shift = next_pat;
  always @(posedge pad_clk)   pad_shift = {1'b1, pad_shift[15:1]};
  assign pad_data = tie ? 1'b1 : pad_shift[0];

  function automatic logic [12:0] model_decode(input logic [15:0] raw);
    logic [12:0] v;
    logic s;
    int idx;
    s = (raw[15:12] == 4'hF);
    v = '0;
    v[12] = s;
    for (int i = 0; i < 12; i++) begin
      idx = s ? snes_map[i] : nes_map[i];
      if (idx >= 0) v[11 - i] = ~raw[idx];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  wire [12:0] dut_btn = {is_snes, A_out, B_out, select_out, start_out, up_out, down_out,
                         left_out, right_out, X_out, Y_out, L_out, R_out};
  wire [15:0] dut_vec = {pad_latch, pad_clk, buttons_valid, dut_btn};

  // reference model: timing derived from cycles since reset release
  int          cyc = 0;
  int          t   = 0;
  int          ph, u;
  logic [15:0] m_pat   = 16'hFFFF;
  logic        e_latch = 1'b0, e_clk = 1'b0, e_valid = 1'b0;
  logic [12:0] e_btn   = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      t = 0; e_latch = 0; e_clk = 0; e_valid = 0; e_btn = '0;
    end else begin
      t++;
      ph = (t - 1) % P;
      u  = ph - L;
      if (ph == 0) m_pat = tie ? 16'hFFFF : next_pat;
      e_latch = (ph < L);
      e_clk   = (u >= 0) && (u < 30 * H) && ((u % (2 * H)) < H);
      e_valid = (ph == VALID_PH);
      if (e_valid) e_btn = model_decode(m_pat);
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("cycle_outputs", 32'(dut_vec), 32'({e_latch, e_clk, e_valid, e_btn}));
  end

  // observers of DUT waveforms for the explicit timing checks
  int   last_rise = 0, prev_rise = 0, clk_rises = 0, latch_w = 0;
  int   valid_cnt = 0, last_lat = 0, last_pulses = 0, last_latch_w = 0;
  logic prev_latch = 0, prev_clk = 0;

  always @(negedge clk) begin
    if (pad_latch && !prev_latch) begin
      prev_rise = last_rise; last_rise = cyc; clk_rises = 0; latch_w = 0;
    end
    if (pad_latch) latch_w++;
    if (pad_clk && !prev_clk) clk_rises++;
    if (buttons_valid) begin
      valid_cnt++; last_lat = cyc - last_rise; last_pulses = clk_rises; last_latch_w = latch_w;
    end
    prev_latch = pad_latch;
    prev_clk   = pad_clk;
  end

  task automatic wait_valid(input int bound, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (buttons_valid) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check(tag, 32'(seen), 32'd1);
  endtask

  function automatic logic [15:0] rand_pat();
    case ($urandom_range(0, 2))
      0:       return {8'h00, 8'($urandom)};
      1:       return {4'hF, 12'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int v0;
    logic seen;
    @(posedge clk); #2;
    chk_en = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("reset_outputs", 32'(dut_vec), 32'h0);

    check("model_nes_a_up", 32'(model_decode(16'h00EE)), 32'h0880);
    check("model_snes_bxr", 32'(model_decode(16'hF5FE)), 32'h1409);
    check("model_all_ones", 32'(model_decode(16'hFFFF)), 32'h1000);

    next_pat = 16'h00EE;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("first_latch_after_reset", 32'(pad_latch), 32'd1);
    wait_valid(2 * P, "nes_valid_seen");
    check("nes_buttons", 32'(dut_btn), 32'h0880);
    check("valid_latency", 32'(last_lat), 32'(VALID_PH));
    check("pulse_count", 32'(last_pulses), 32'd15);
    check("latch_width", 32'(last_latch_w), 32'(L));

    next_pat = 16'hF5FE;
    wait_valid(P + 20, "snes_valid_seen");
    check("snes_buttons", 32'(dut_btn), 32'h1409);
    check("poll_period", 32'(last_rise - prev_rise), 32'(P));

    tie = 1'b1;
    v0 = valid_cnt;
    repeat (3 * P + P / 2) @(negedge clk);
    #1;
    check("tied_valid_count", 32'(valid_cnt - v0), 32'd3);
    check("tied_buttons", 32'(dut_btn), 32'h1000);
    tie = 1'b0;

    next_pat = 16'h3C5A;
    seen = 1'b0;
    for (int n = 0; n < 2 * P; n++) begin
      @(negedge clk); #1;
      if (clk_rises == 7 && pad_clk) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_pulse7", 32'(seen), 32'd1);
    v0 = valid_cnt;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("abort_outputs", 32'(dut_vec), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("relatch_after_abort", 32'(pad_latch), 32'd1);
    check("no_valid_on_abort", 32'(valid_cnt - v0), 32'd0);
    wait_valid(P, "post_abort_valid");
    check("post_abort_buttons", 32'(dut_btn), 32'(model_decode(16'h3C5A)));

    for (int k = 0; k < 20; k++) begin
      next_pat = rand_pat();
      repeat ($urandom_range(0, 300)) @(posedge clk);
      #2;
      next_pat = rand_pat();
      wait_valid(P + 50, "rand_valid_seen");
      if (k >= 1) check("rand_poll_period", 32'(last_rise - prev_rise), 32'(P));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
